// File: rtl/nios2_hello_nios2_cpu_debug_memctl.sv
// Debug-memory controller: arbitrates a 2^AW x 32 debug RAM between the JTAG
// debug slave (address/data via jdo strobes) and a CPU Avalon slave port, and
// holds the monitor handshake flags (ready/error/go).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   jdo                        JTAG data word from the debug-slave sysclk stage
//   take_action_ocimem_a       load MonAReg, clear/set flags, optional read
//   take_action_ocimem_b       write jdo[34:3] to RAM[MonAReg], increment
//   take_no_action_ocimem_a    read RAM[MonAReg] into MonDReg, increment
//   avs_*                      CPU slave; avs_address MSB selects control reg
//   MonDReg                    last JTAG read data
//   monitor_ready/error/go     monitor handshake flags
module nios2_hello_nios2_cpu_debug_memctl #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic [AW:0]   avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error,
    output logic          monitor_go
);

    typedef enum logic [1:0] {StIdle, StJrd, StCrd} state_e;
    typedef enum logic [1:0] {OpNone, OpA, OpB, OpNext} op_e;

    state_e          state_q, state_d;
    logic            pend_valid_q;
    op_e             pend_op_q;
    logic [37:0]     pend_jdo_q;
    logic [AW-1:0]   mon_a_q;
    logic [31:0]     mon_d_q;
    logic            ready_q, error_q, go_q;

    logic [31:0]     mem [2**AW];
    logic [31:0]     ram_q;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [3:0]      ram_be;
    logic [31:0]     ram_wdata;

    op_e             new_op, jtag_op;
    logic [37:0]     jtag_jdo;
    logic            cpu_req, ctrl_sel, ctrl_wr;
    logic [31:0]     ctrl_rdata;

    logic            unused_bits;
    assign unused_bits = ^{jdo[37:36], jdo[2:0], pend_jdo_q[37:36], pend_jdo_q[2:0]};

    // Same-cycle strobes: ocimem_a > ocimem_b > no_action_a.
    always_comb begin
        new_op = OpNone;
        if (take_action_ocimem_a)         new_op = OpA;
        else if (take_action_ocimem_b)    new_op = OpB;
        else if (take_no_action_ocimem_a) new_op = OpNext;
    end

    // Only IDLE services JTAG; a held strobe beats a new one, which is dropped.
    assign jtag_op  = (state_q != StIdle) ? OpNone : (pend_valid_q ? pend_op_q : new_op);
    assign jtag_jdo = pend_valid_q ? pend_jdo_q : jdo;

    assign cpu_req    = avs_read | avs_write;
    assign ctrl_sel   = avs_address[AW];
    assign ctrl_rdata = {29'b0, go_q, error_q, ready_q};

    always_comb begin
        state_d         = state_q;
        ram_addr        = mon_a_q;
        ram_we          = 1'b0;
        ram_be          = 4'h0;
        ram_wdata       = 32'h0;
        avs_waitrequest = cpu_req;
        avs_readdata    = 32'h0;
        ctrl_wr         = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (jtag_op != OpNone) begin
                        unique case (jtag_op)
                            OpA: begin
                                if (jtag_jdo[17]) begin
                                    ram_addr = jtag_jdo[AW+18:19];
                                    state_d  = StJrd;
                                end
                            end
                            OpB: begin
                                ram_we    = 1'b1;
                                ram_be    = 4'hf;
                                ram_wdata = jtag_jdo[34:3];
                            end
                            OpNext:  state_d = StJrd;
                            default: ;
                        endcase
                    end else if (cpu_req) begin
                        if (ctrl_sel) begin
                            avs_waitrequest = 1'b0;
                            ctrl_wr         = avs_write;
                            if (avs_read) avs_readdata = ctrl_rdata;
                        end else if (avs_write) begin
                            avs_waitrequest = 1'b0;
                            ram_addr        = avs_address[AW-1:0];
                            ram_we          = 1'b1;
                            ram_be          = avs_byteenable;
                            ram_wdata       = avs_writedata;
                        end else begin
                            // Granted read: address RAM now, data in CRD.
                            ram_addr = avs_address[AW-1:0];
                            state_d  = StCrd;
                        end
                    end
                end
                StJrd: begin
                    state_d = StIdle;
                    if (cpu_req && ctrl_sel) begin
                        avs_waitrequest = 1'b0;
                        ctrl_wr         = avs_write;
                        if (avs_read) avs_readdata = ctrl_rdata;
                    end
                end
                StCrd: begin
                    state_d = StIdle;
                    if (cpu_req && ctrl_sel) begin
                        avs_waitrequest = 1'b0;
                        ctrl_wr         = avs_write;
                        if (avs_read) avs_readdata = ctrl_rdata;
                    end else if (avs_read) begin
                        avs_waitrequest = 1'b0;
                        avs_readdata    = ram_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_op_q    <= OpNone;
            pend_jdo_q   <= '0;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            go_q         <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q != StIdle) begin
                if (new_op != OpNone && !pend_valid_q) begin
                    pend_valid_q <= 1'b1;
                    pend_op_q    <= new_op;
                    pend_jdo_q   <= jdo;
                end
            end else if (pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end

            unique case (jtag_op)
                OpA:     mon_a_q <= jtag_jdo[AW+18:19];
                OpB:     mon_a_q <= mon_a_q + AW'(1);
                default: ;
            endcase

            // Leaving JRD: RAM output for the addressed word is valid now.
            if (state_q == StJrd) begin
                mon_d_q <= ram_q;
                mon_a_q <= mon_a_q + AW'(1);
            end

            if (ctrl_wr) begin
                if (avs_writedata[0]) ready_q <= 1'b1;
                if (avs_writedata[1]) error_q <= 1'b1;
                if (avs_writedata[2]) go_q    <= 1'b0;
            end
            // JTAG updates come last so they win any same-cycle conflict.
            if (jtag_op == OpA) begin
                if (jtag_jdo[35]) begin
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                end
                if (jtag_jdo[23]) go_q <= 1'b1;
            end
        end
    end

    // Debug RAM: single port, registered read, byte-lane write, no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        ram_q <= mem[ram_addr];
    end

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign monitor_go    = go_q;

endmodule

// File: tb/tb_nios2_hello_nios2_cpu_debug_memctl.sv
// Directed self-checking bench for nios2_hello_nios2_cpu_debug_memctl (AW=8).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
module tb_nios2_hello_nios2_cpu_debug_memctl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [8:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go;

    int tests = 0;
    int errors = 0;

    nios2_hello_nios2_cpu_debug_memctl #(.AW(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // With AW=8 the address field jdo[26:19] overlaps jdo[23] (address bit 4).
    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd,
                                          input logic clr, input logic go);
        logic [37:0] j;
        j       = '0;
        j[26:19] = addr;
        j[17]   = rd;
        j[35]   = clr;
        if (go) j[23] = 1'b1;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j      = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe_a(input logic [7:0] addr, input logic rd, input logic clr,
                            input logic go);
        jdo = jdo_a(addr, rd, clr, go);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        jdo = '0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        jdo = jdo_b(d);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        avs_read = 1'b1;
        avs_address = 9'h010;
        tick();
        tick();
        #1;
        tests++;
        if (avs_waitrequest !== 1'b1) begin
            errors++; $display("FAIL reset_wait: got %b expected 1", avs_waitrequest);
        end
        tests++;
        if (MonDReg !== 32'h0) begin
            errors++; $display("FAIL reset_mond: got %h expected 00000000", MonDReg);
        end
        tests++;
        if ({monitor_ready, monitor_error, monitor_go} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000",
                               {monitor_ready, monitor_error, monitor_go});
        end
        tests++;
        if (dut.mon_a_q !== 8'h00) begin
            errors++; $display("FAIL reset_mona: got %h expected 00", dut.mon_a_q);
        end
        avs_read = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h0) begin
            errors++; $display("FAIL idle_bus: got wait=%b data=%h expected 0/0",
                               avs_waitrequest, avs_readdata);
        end
    endtask

    task automatic test_jtag_write();
        strobe_a(8'h10, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut.mon_a_q !== 8'h10 || monitor_go !== 1'b1) begin
            errors++; $display("FAIL load_addr: got mona=%h go=%b expected 10/1",
                               dut.mon_a_q, monitor_go);
        end
        strobe_b(32'hDEADBEEF);
        tests++;
        if (dut.mon_a_q !== 8'h11) begin
            errors++; $display("FAIL write_inc: got %h expected 11", dut.mon_a_q);
        end
        strobe_b(32'hCAFEF00D);
        tests++;
        if (dut.mon_a_q !== 8'h12) begin
            errors++; $display("FAIL write_inc2: got %h expected 12", dut.mon_a_q);
        end
    endtask

    task automatic test_jtag_read();
        strobe_a(8'h10, 1'b1, 1'b0, 1'b0);
        tests++;
        if (MonDReg !== 32'h0) begin
            errors++; $display("FAIL read_latency: got %h expected 00000000", MonDReg);
        end
        tick();
        tests++;
        if (MonDReg !== 32'hDEADBEEF || dut.mon_a_q !== 8'h11) begin
            errors++; $display("FAIL read_a: got %h/%h expected DEADBEEF/11",
                               MonDReg, dut.mon_a_q);
        end
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        tick();
        tests++;
        if (MonDReg !== 32'hCAFEF00D || dut.mon_a_q !== 8'h12) begin
            errors++; $display("FAIL read_next: got %h/%h expected CAFEF00D/12",
                               MonDReg, dut.mon_a_q);
        end
    endtask

    task automatic test_wrap();
        strobe_a(8'hFF, 1'b0, 1'b0, 1'b0);
        strobe_b(32'h12345678);
        tests++;
        if (dut.mon_a_q !== 8'h00) begin
            errors++; $display("FAIL wrap_write: got %h expected 00", dut.mon_a_q);
        end
        strobe_a(8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        tests++;
        if (MonDReg !== 32'h12345678 || dut.mon_a_q !== 8'h00) begin
            errors++; $display("FAIL wrap_read: got %h/%h expected 12345678/00",
                               MonDReg, dut.mon_a_q);
        end
    endtask

    task automatic test_cpu_ram();
        avs_write = 1'b1;
        avs_address = 9'h020;
        avs_writedata = 32'hAABBCCDD;
        avs_byteenable = 4'hF;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b0) begin
            errors++; $display("FAIL cpu_wr_wait: got %b expected 0", avs_waitrequest);
        end
        tick();
        avs_writedata = 32'h11223344;
        avs_byteenable = 4'b0101;
        tick();
        avs_write = 1'b0;
        avs_read = 1'b1;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b1) begin
            errors++; $display("FAIL cpu_rd_grant: got %b expected 1", avs_waitrequest);
        end
        tick();
        tests++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'hAA22CC44) begin
            errors++; $display("FAIL cpu_rd_be: got wait=%b data=%h expected 0/AA22CC44",
                               avs_waitrequest, avs_readdata);
        end
        tick();
        avs_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        strobe_a(8'h10, 1'b0, 1'b0, 1'b0);
        avs_read = 1'b1;
        avs_address = 9'h010;
        jdo = jdo_b(32'h0BADF00D);
        take_action_ocimem_b = 1'b1;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b1) begin
            errors++; $display("FAIL b2b_wait0: got %b expected 1", avs_waitrequest);
        end
        tick();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b1) begin
            errors++; $display("FAIL b2b_wait1: got %b expected 1", avs_waitrequest);
        end
        tick();
        tests++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h0BADF00D) begin
            errors++; $display("FAIL b2b_data: got wait=%b data=%h expected 0/0BADF00D",
                               avs_waitrequest, avs_readdata);
        end
        tick();
        avs_read = 1'b0;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h0) begin
            errors++; $display("FAIL b2b_idle: got wait=%b data=%h expected 0/0",
                               avs_waitrequest, avs_readdata);
        end
    endtask

    task automatic test_control();
        avs_address = 9'h100;
        avs_write = 1'b1;
        avs_writedata = 32'h4;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b0) begin
            errors++; $display("FAIL ctrl_wr_wait: got %b expected 0", avs_waitrequest);
        end
        tick();
        tests++;
        if (monitor_go !== 1'b0) begin
            errors++; $display("FAIL ctrl_clr_go: got %b expected 0", monitor_go);
        end
        avs_writedata = 32'h3;
        tick();
        avs_writedata = 32'h0;
        tick();
        avs_write = 1'b0;
        tests++;
        if ({monitor_ready, monitor_error, monitor_go} !== 3'b110) begin
            errors++; $display("FAIL ctrl_set: got %b expected 110",
                               {monitor_ready, monitor_error, monitor_go});
        end
        avs_read = 1'b1;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h3) begin
            errors++; $display("FAIL ctrl_rd: got wait=%b data=%h expected 0/00000003",
                               avs_waitrequest, avs_readdata);
        end
        tick();
        avs_read = 1'b0;
        // JTAG clear/go and a CPU set in the same cycle: JTAG is served first.
        jdo = jdo_a(8'h00, 1'b0, 1'b1, 1'b1);
        take_action_ocimem_a = 1'b1;
        avs_write = 1'b1;
        avs_writedata = 32'h3;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b1) begin
            errors++; $display("FAIL ctrl_conflict_wait: got %b expected 1", avs_waitrequest);
        end
        tick();
        take_action_ocimem_a = 1'b0;
        jdo = '0;
        tests++;
        if ({monitor_ready, monitor_error, monitor_go} !== 3'b001) begin
            errors++; $display("FAIL jtag_clr_go: got %b expected 001",
                               {monitor_ready, monitor_error, monitor_go});
        end
        tick();
        avs_writedata = 32'h4;
        tick();
        avs_write = 1'b0;
        tests++;
        if ({monitor_ready, monitor_error, monitor_go} !== 3'b110) begin
            errors++; $display("FAIL ctrl_after: got %b expected 110",
                               {monitor_ready, monitor_error, monitor_go});
        end
    endtask

    task automatic test_pending();
        strobe_a(8'h10, 1'b1, 1'b0, 1'b0);
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        tests++;
        if (MonDReg !== 32'h0BADF00D) begin
            errors++; $display("FAIL pend_first: got %h expected 0BADF00D", MonDReg);
        end
        // Pending read is serviced this cycle; this write strobe is dropped.
        jdo = jdo_b(32'h55555555);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        tick();
        tests++;
        if (MonDReg !== 32'hCAFEF00D || dut.mon_a_q !== 8'h12) begin
            errors++; $display("FAIL pend_serviced: got %h/%h expected CAFEF00D/12",
                               MonDReg, dut.mon_a_q);
        end
    endtask

    task automatic test_reset_mid_jrd();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        strobe_a(8'h10, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (MonDReg !== 32'h0 || dut.mon_a_q !== 8'h00 || monitor_go !== 1'b0) begin
            errors++; $display("FAIL abort_jrd: got %h/%h/%b expected 00000000/00/0",
                               MonDReg, dut.mon_a_q, monitor_go);
        end
        avs_address = 9'h030;
        avs_write = 1'b1;
        avs_writedata = 32'h1;
        avs_byteenable = 4'hF;
        #1;
        tests++;
        if (avs_waitrequest !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got %b expected 0", avs_waitrequest);
        end
        tick();
        avs_write = 1'b0;
        tick();
        tests++;
        if (MonDReg !== 32'h0) begin
            errors++; $display("FAIL abort_mond_hold: got %h expected 00000000", MonDReg);
        end
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        test_reset();
        test_jtag_write();
        test_jtag_read();
        test_wrap();
        test_cpu_ram();
        test_back_to_back();
        test_control();
        test_pending();
        test_reset_mid_jrd();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
